// File: rtl/bus_cmd_pkg.sv
// rtl/bus_cmd_pkg.sv - opcodes, response codes, states and frame sizes for the command bridge
package bus_cmd_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;

    localparam int ADDR_BYTES = 4;
    localparam int DATA_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_BUS,
        ST_RD_WAIT,
        ST_RESP
    } state_t;

    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WRITE) || (b == OP_READ);
    endfunction

endpackage

// File: rtl/resp_serializer.sv
// rtl/resp_serializer.sv - sends a 1- or 4-byte response MSB first over a valid/ready handshake
module resp_serializer (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        word,
    input  logic [31:0] load_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        done
);

    logic [31:0] shift_q, shift_d;
    logic [2:0]  left_q, left_d;
    logic        valid_q, valid_d;

    always_comb begin
        shift_d = shift_q;
        left_d  = left_q;
        valid_d = valid_q;
        done    = 1'b0;
        if (load) begin
            shift_d = load_data;
            left_d  = word ? 3'd4 : 3'd1;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready) begin
            if (left_q == 3'd1) begin
                // clear the byte so tx_data idles at zero between responses
                shift_d = 32'h0;
                left_d  = 3'd0;
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                shift_d = {shift_q[23:0], 8'h00};
                left_d  = left_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q <= 32'h0;
            left_q  <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            shift_q <= shift_d;
            left_q  <= left_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data  = shift_q[31:24];
    assign tx_valid = valid_q;

endmodule

// File: rtl/bus_cmd_bridge.sv
// rtl/bus_cmd_bridge.sv - byte-stream command bridge issuing single-word peripheral bus reads/writes
module bus_cmd_bridge
    import bus_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1_250_000,
    parameter int READ_LATENCY   = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        CS_N,
    output logic        RD_N,
    output logic        WR_N,
    output logic [31:0] Addr,
    output logic [31:0] DataOut,
    input  logic [31:0] DataIn,
    output logic        overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    LAT_LAST = 2'(READ_LATENCY - 1);
    localparam logic [1:0]    ADDR_LAST = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]    DATA_LAST = 2'(DATA_BYTES - 1);

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   data_q, data_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          is_wr_q, is_wr_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    lat_q, lat_d;
    logic          bus_req_q, bus_req_d;
    logic          overrun_q, overrun_d;

    logic          rsp_load;
    logic          rsp_word;
    logic [31:0]   rsp_data;
    logic          rsp_done;
    logic          strobe;

    // the grant only gates the strobe while the registered state says BUS
    assign strobe = (state_q == ST_BUS) && bus_gnt;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        cnt_d     = cnt_q;
        is_wr_d   = is_wr_q;
        tmo_d     = tmo_q;
        lat_d     = lat_q;
        overrun_d = overrun_q;
        rsp_load  = 1'b0;
        rsp_word  = 1'b0;
        rsp_data  = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (rx_valid) begin
                    if (is_opcode(rx_data)) begin
                        state_d = ST_ADDR;
                        cnt_d   = 2'd0;
                        tmo_d   = '0;
                        is_wr_d = (rx_data == OP_WRITE);
                    end else begin
                        state_d  = ST_RESP;
                        rsp_load = 1'b1;
                        rsp_data = {RSP_ERR, 24'h0};
                    end
                end
            end
            ST_ADDR, ST_DATA: begin
                if (rx_valid) begin
                    tmo_d = '0;
                    cnt_d = cnt_q + 2'd1;
                    if (state_q == ST_ADDR) begin
                        addr_d = {addr_q[23:0], rx_data};
                        if (cnt_q == ADDR_LAST) begin
                            cnt_d   = 2'd0;
                            state_d = is_wr_q ? ST_DATA : ST_BUS;
                        end
                    end else begin
                        data_d = {data_q[23:0], rx_data};
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = 2'd0;
                            state_d = ST_BUS;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tmo_d   = '0;
                    cnt_d   = 2'd0;
                    state_d = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_BUS: begin
                if (bus_gnt) begin
                    if (is_wr_q) begin
                        state_d  = ST_RESP;
                        rsp_load = 1'b1;
                        rsp_data = {RSP_OK, 24'h0};
                    end else begin
                        state_d = ST_RD_WAIT;
                        lat_d   = 2'd0;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (lat_q == LAT_LAST) begin
                    state_d  = ST_RESP;
                    rsp_load = 1'b1;
                    rsp_word = 1'b1;
                    rsp_data = DataIn;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            ST_RESP: begin
                if (rsp_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (rx_valid && (state_q == ST_BUS || state_q == ST_RD_WAIT || state_q == ST_RESP)) begin
            overrun_d = 1'b1;
        end

        bus_req_d = (state_d == ST_BUS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'h0;
            data_q    <= 32'h0;
            cnt_q     <= 2'd0;
            is_wr_q   <= 1'b0;
            tmo_q     <= '0;
            lat_q     <= 2'd0;
            bus_req_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            cnt_q     <= cnt_d;
            is_wr_q   <= is_wr_d;
            tmo_q     <= tmo_d;
            lat_q     <= lat_d;
            bus_req_q <= bus_req_d;
            overrun_q <= overrun_d;
        end
    end

    resp_serializer u_resp (
        .clk       (clk),
        .reset     (reset),
        .load      (rsp_load),
        .word      (rsp_word),
        .load_data (rsp_data),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .done      (rsp_done)
    );

    assign bus_req = bus_req_q;
    assign CS_N    = ~strobe;
    assign WR_N    = ~(strobe && is_wr_q);
    assign RD_N    = ~(strobe && !is_wr_q);
    assign Addr    = addr_q;
    assign DataOut = data_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_bus_cmd_bridge.sv
// tb/tb_bus_cmd_bridge.sv - directed self-checking bench for bus_cmd_bridge
module tb_bus_cmd_bridge;

    localparam int TMO = 16;
    localparam int RL  = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        bus_req;
    logic        bus_gnt;
    logic        CS_N, RD_N, WR_N;
    logic [31:0] Addr, DataOut, DataIn;
    logic        overrun;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    bus_cmd_bridge #(.TIMEOUT_CYCLES(TMO), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .bus_req(bus_req), .bus_gnt(bus_gnt),
        .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
        .Addr(Addr), .DataOut(DataOut), .DataIn(DataIn),
        .overrun(overrun)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [71:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8]);
    endtask

    task automatic collect_rsp(input int n, input int budget, output logic [31:0] word, output int got);
        word = 32'h0;
        got  = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            tx_ready = 1'b1;
            @(negedge clk);
            if (tx_valid) begin
                word = {word[23:0], tx_data};
                got++;
            end
            step();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
        bus_gnt = 1'b1; DataIn = 32'hFFFF_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({CS_N, RD_N, WR_N, bus_req, tx_valid, overrun} !== 6'b111000 || tx_data !== 8'h00
            || Addr !== 32'h0 || DataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_values: CS_N%b RD_N%b WR_N%b req%b txv%b ovr%b txd=%h Addr=%h DOut=%h required 111000 00 0 0",
                     CS_N, RD_N, WR_N, bus_req, tx_valid, overrun, tx_data, Addr, DataOut);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        step();
    endtask

    task automatic test_write();
        bus_gnt = 1'b1; tx_ready = 1'b1;
        send_frame(72'h57_10000000_DEADBEEF, 9);
        @(negedge clk);
        checks++;
        if ({CS_N, WR_N, RD_N, bus_req} !== 4'b0011) begin
            errors++;
            $display("FAIL write_strobe: CS_N,WR_N,RD_N,req=%b required 0011", {CS_N, WR_N, RD_N, bus_req});
        end
        checks++;
        if (Addr !== 32'h1000_0000 || DataOut !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL write_bus: Addr=%h DataOut=%h required 10000000 deadbeef", Addr, DataOut);
        end
        step();
        @(negedge clk);
        checks++;
        if (CS_N !== 1'b1 || bus_req !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'h4B) begin
            errors++;
            $display("FAIL write_resp: CS_N=%b req=%b txv=%b txd=%h required 1 0 1 4b", CS_N, bus_req, tx_valid, tx_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL write_resp_end: tx_valid=%b required 0", tx_valid);
        end
        step();
    endtask

    task automatic test_read_toggle();
        logic [7:0] got [4];
        logic [7:0] hold;
        logic       hold_v;
        int         n;
        bus_gnt = 1'b1; tx_ready = 1'b1;
        send_frame(72'h52_00002004, 5);
        @(negedge clk);
        checks++;
        if ({CS_N, RD_N, WR_N} !== 3'b001 || Addr !== 32'h0000_2004) begin
            errors++;
            $display("FAIL read_strobe: CS_N,RD_N,WR_N=%b Addr=%h required 001 00002004", {CS_N, RD_N, WR_N}, Addr);
        end
        step();
        DataIn = 32'h1234_5678;
        step();
        DataIn = 32'hFFFF_0000;
        n = 0; hold_v = 1'b0; hold = 8'h00;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tx_ready = c[0];
            @(negedge clk);
            if (hold_v) begin
                checks++;
                if (tx_data !== hold || tx_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL read_hold: tx_data=%h txv=%b required %h 1", tx_data, tx_valid, hold);
                end
            end
            hold_v = tx_valid && !tx_ready;
            hold   = tx_data;
            if (tx_valid && tx_ready) begin
                got[n] = tx_data;
                n++;
            end
            step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL read_count: got %0d bytes required 4", n);
        end else begin
            checks++;
            if ({got[0], got[1], got[2], got[3]} !== 32'h1234_5678) begin
                errors++;
                $display("FAIL read_bytes: %h %h %h %h required 12 34 56 78", got[0], got[1], got[2], got[3]);
            end
        end
        tx_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL read_end: tx_valid=%b required 0", tx_valid);
        end
        step();
    endtask

    task automatic test_gnt_wait();
        int          bad;
        int          got;
        logic [31:0] w;
        bus_gnt = 1'b0; tx_ready = 1'b1;
        send_frame(72'h52_00000040, 5);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus_req !== 1'b1 || CS_N !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL gnt_wait_hold: %0d bad cycles required 0 (req=1, no strobe)", bad);
        end
        bus_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({CS_N, RD_N} !== 2'b00 || bus_req !== 1'b1) begin
            errors++;
            $display("FAIL gnt_wait_strobe: CS_N,RD_N=%b req=%b required 00 1", {CS_N, RD_N}, bus_req);
        end
        step();
        @(negedge clk);
        checks++;
        if (bus_req !== 1'b0 || CS_N !== 1'b1) begin
            errors++;
            $display("FAIL gnt_wait_release: req=%b CS_N=%b required 0 1", bus_req, CS_N);
        end
        step();
        collect_rsp(4, 20, w, got);
        checks++;
        if (got != 4 || w !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL gnt_wait_resp: got %0d bytes word=%h required 4 ffff0000", got, w);
        end
    endtask

    task automatic test_timeout();
        int          bad;
        int          got;
        logic [31:0] w;
        bus_gnt = 1'b1; tx_ready = 1'b1; DataIn = 32'hCAFE_F00D;
        send_byte(8'h57);
        send_byte(8'h10);
        bad = 0;
        for (int c = 0; c < TMO; c++) begin
            @(negedge clk);
            if (tx_valid !== 1'b0 || CS_N !== 1'b1) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_quiet: %0d cycles with tx or strobe required 0", bad);
        end
        send_frame(72'h52_00003000, 5);
        @(negedge clk);
        checks++;
        if ({CS_N, RD_N} !== 2'b00 || Addr !== 32'h0000_3000) begin
            errors++;
            $display("FAIL timeout_next_strobe: CS_N,RD_N=%b Addr=%h required 00 00003000", {CS_N, RD_N}, Addr);
        end
        step();
        collect_rsp(4, 20, w, got);
        checks++;
        if (got != 4 || w !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL timeout_next_resp: got %0d word=%h required 4 cafef00d", got, w);
        end
    endtask

    task automatic test_timeout_edge();
        int          got;
        logic [31:0] w;
        bus_gnt = 1'b1; tx_ready = 1'b1; DataIn = 32'h0BAD_CAFE;
        send_byte(8'h52);
        send_byte(8'h00);
        repeat (TMO - 1) step();
        send_byte(8'h00);
        send_byte(8'h00);
        send_byte(8'h44);
        @(negedge clk);
        checks++;
        if ({CS_N, RD_N} !== 2'b00 || Addr !== 32'h0000_0044) begin
            errors++;
            $display("FAIL timeout_edge_strobe: CS_N,RD_N=%b Addr=%h required 00 00000044", {CS_N, RD_N}, Addr);
        end
        step();
        collect_rsp(4, 20, w, got);
        checks++;
        if (got != 4 || w !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL timeout_edge_resp: got %0d word=%h required 4 0badcafe", got, w);
        end
    endtask

    task automatic test_error_overrun();
        tx_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0) begin
            errors++;
            $display("FAIL overrun_initial: overrun=%b required 0", overrun);
        end
        step();
        send_byte(8'h41);
        send_byte(8'h57);
        send_byte(8'h52);
        @(negedge clk);
        checks++;
        if (overrun !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h45) begin
            errors++;
            $display("FAIL error_pending: ovr=%b txv=%b txd=%h required 1 1 45", overrun, tx_valid, tx_data);
        end
        step();
        tx_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL error_end: tx_valid=%b required 0", tx_valid);
        end
        step();
        send_byte(8'h41);
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h45) begin
            errors++;
            $display("FAIL error_again: txv=%b txd=%h required 1 45 (dropped bytes must not start a frame)", tx_valid, tx_data);
        end
        step();
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL error_again_end: txv=%b ovr=%b required 0 1", tx_valid, overrun);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int bad;
        bus_gnt = 1'b1; tx_ready = 1'b1;
        send_frame(72'h57_10000000_DEAD, 7);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({CS_N, RD_N, WR_N, bus_req, tx_valid, overrun} !== 6'b111000 || tx_data !== 8'h00
            || Addr !== 32'h0 || DataOut !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: CS_N%b RD_N%b WR_N%b req%b txv%b ovr%b txd=%h Addr=%h DOut=%h required 111000 00 0 0",
                     CS_N, RD_N, WR_N, bus_req, tx_valid, overrun, tx_data, Addr, DataOut);
        end
        step();
        reset = 1'b0;
        step();
        send_byte(8'hBE);
        send_byte(8'hEF);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (CS_N !== 1'b1 || bus_req !== 1'b0) bad++;
            step();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_mid_no_strobe: %0d strobe/req cycles required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_toggle();
        test_gnt_wait();
        test_timeout();
        test_timeout_edge();
        test_error_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
